// File: rtl/icb_mem_arbiter_pkg.sv
// Shared definitions for the two-master ICB memory arbiter.
//   - Default ICB field widths.
//   - Grant-ID encoding stored in the outstanding FIFO (MST_CORE=0, MST_EXT=1).
//   - mst_other(): returns the opposite master, used for the round-robin pointer update.
package icb_mem_arbiter_pkg;

  localparam int unsigned DefaultAw        = 32;
  localparam int unsigned DefaultDw        = 32;
  localparam int unsigned DefaultMw        = DefaultDw / 8;
  localparam int unsigned DefaultOutsDepth = 4;

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_EXT  = 1'b1
  } icb_mst_e;

  function automatic icb_mst_e mst_other(input icb_mst_e m);
    return (m == MST_CORE) ? MST_EXT : MST_CORE;
  endfunction

endpackage

// File: rtl/icb_arb_outs_fifo.sv
// Outstanding-command FIFO for the ICB arbiter: holds the 1-bit grant ID of every
// command issued to the slave so responses can be routed back in order.
// Ports:
//   clk, rst_n     clock, asynchronous active-low clear
//   push, din      enqueue a grant ID (ignored when full)
//   pop            dequeue the head (ignored when empty)
//   dout           head entry
//   full, empty    occupancy flags
//   count          number of stored entries, 0..Depth
module icb_arb_outs_fifo #(
  parameter int unsigned Depth = 4  // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of 2, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/icb_mem_arbiter.sv
// Two-master, one-slave ICB arbiter. m0 is the core's mem ICB port, m1 an external/debug
// DMA requester; both share one memory slave.
//   - Command path is a zero-latency combinational pass-through of the granted master.
//   - Grant is round-robin per command; a command presented but stalled by the slave is
//     locked so it stays stable until its handshake.
//   - An in-order FIFO of grant IDs steers each slave response back to its issuer.
// Configuration macro:
//   ICB_ARB_FIXED_PRIO_EN  when defined, m0 always wins a tie and no round-robin pointer
//                          exists; the lock still applies.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m{0,1}_icb_cmd_*           master command channels (valid/ready/addr/read/wdata/wmask)
//   m{0,1}_icb_rsp_*           master response channels (valid/ready/err/rdata)
//   s_icb_cmd_*, s_icb_rsp_*   slave command/response channels
//   arb_busy                   at least one command outstanding
module icb_mem_arbiter
  import icb_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned DW         = DefaultDw,
  parameter int unsigned OUTS_DEPTH = DefaultOutsDepth
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic            m0_icb_cmd_read,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,

  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic            m1_icb_cmd_read,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,

  output logic            s_icb_cmd_valid,
  input  logic            s_icb_cmd_ready,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic            s_icb_cmd_read,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_rsp_valid,
  output logic            s_icb_rsp_ready,
  input  logic            s_icb_rsp_err,
  input  logic [DW-1:0]   s_icb_rsp_rdata,

  output logic            arb_busy
);

  localparam int unsigned CntW = $clog2(OUTS_DEPTH) + 1;

  icb_mst_e        grant;
  icb_mst_e        tie_winner;
  icb_mst_e        lock_id_q, lock_id_d;
  icb_mst_e        head;
  logic            lock_q, lock_d;
  logic            gnt_valid;
  logic            cmd_accept;
  logic            cmd_hsk;
  logic            rsp_hsk;
  logic            fifo_full, fifo_empty, fifo_head;
  logic [CntW-1:0] fifo_count;

`ifdef ICB_ARB_FIXED_PRIO_EN
  assign tie_winner = MST_CORE;
`else
  icb_mst_e rr_ptr_q, rr_ptr_d;

  assign tie_winner = rr_ptr_q;
  assign rr_ptr_d   = cmd_hsk ? mst_other(grant) : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= MST_CORE;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------------------
  // Command arbitration
  // ---------------------------------------------------------------------------------------
  always_comb begin
    grant = tie_winner;
    if (lock_q) begin
      grant = lock_id_q;
    end else begin
      unique case ({m1_icb_cmd_valid, m0_icb_cmd_valid})
        2'b01:   grant = MST_CORE;
        2'b10:   grant = MST_EXT;
        default: grant = tie_winner;
      endcase
    end
  end

  assign gnt_valid = (grant == MST_EXT) ? m1_icb_cmd_valid : m0_icb_cmd_valid;

  // Full blocks issue even if a response pops this cycle; qualifying with rst_n keeps every
  // handshake output low while reset is asserted.
  assign s_icb_cmd_valid  = rst_n & gnt_valid & ~fifo_full;
  assign cmd_accept       = rst_n & s_icb_cmd_ready & ~fifo_full;
  assign m0_icb_cmd_ready = cmd_accept & (grant == MST_CORE);
  assign m1_icb_cmd_ready = cmd_accept & (grant == MST_EXT);
  assign cmd_hsk          = s_icb_cmd_valid & s_icb_cmd_ready;

  always_comb begin
    if (grant == MST_EXT) begin
      s_icb_cmd_addr  = m1_icb_cmd_addr;
      s_icb_cmd_read  = m1_icb_cmd_read;
      s_icb_cmd_wdata = m1_icb_cmd_wdata;
      s_icb_cmd_wmask = m1_icb_cmd_wmask;
    end else begin
      s_icb_cmd_addr  = m0_icb_cmd_addr;
      s_icb_cmd_read  = m0_icb_cmd_read;
      s_icb_cmd_wdata = m0_icb_cmd_wdata;
      s_icb_cmd_wmask = m0_icb_cmd_wmask;
    end
  end

  // A presented-but-stalled command pins the grant until it is accepted.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (cmd_hsk) begin
      lock_d = 1'b0;
    end else if (s_icb_cmd_valid) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= MST_CORE;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outstanding tracking and response routing
  // ---------------------------------------------------------------------------------------
  icb_arb_outs_fifo #(
    .Depth (OUTS_DEPTH)
  ) u_outs_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_hsk),
    .din   (grant),
    .pop   (rsp_hsk),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head = icb_mst_e'(fifo_head);

  // A slave response while nothing is outstanding is dropped: not forwarded, not accepted.
  assign m0_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty & (head == MST_CORE);
  assign m1_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty & (head == MST_EXT);
  assign m0_icb_rsp_err   = s_icb_rsp_err;
  assign m1_icb_rsp_err   = s_icb_rsp_err;
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

  assign s_icb_rsp_ready = ~fifo_empty & ((head == MST_EXT) ? m1_icb_rsp_ready
                                                            : m0_icb_rsp_ready);
  assign rsp_hsk         = s_icb_rsp_valid & s_icb_rsp_ready;

  assign arb_busy = (fifo_count != '0);

endmodule

// File: tb/tb_icb_mem_arbiter.sv
// Directed self-checking bench for icb_mem_arbiter (OUTS_DEPTH=4).
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
module tb_icb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst_n;
  logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [AW-1:0]   m0_icb_cmd_addr;
  logic [DW-1:0]   m0_icb_cmd_wdata;
  logic [DW/8-1:0] m0_icb_cmd_wmask;
  logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [DW-1:0]   m0_icb_rsp_rdata;
  logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [AW-1:0]   m1_icb_cmd_addr;
  logic [DW-1:0]   m1_icb_cmd_wdata;
  logic [DW/8-1:0] m1_icb_cmd_wmask;
  logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [DW-1:0]   m1_icb_rsp_rdata;
  logic            s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [AW-1:0]   s_icb_cmd_addr;
  logic [DW-1:0]   s_icb_cmd_wdata;
  logic [DW/8-1:0] s_icb_cmd_wmask;
  logic            s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [DW-1:0]   s_icb_rsp_rdata;
  logic            arb_busy;

  int errors = 0;
  int checks = 0;

  icb_mem_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .OUTS_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_icb_cmd_valid (m0_icb_cmd_valid),
    .m0_icb_cmd_ready (m0_icb_cmd_ready),
    .m0_icb_cmd_addr  (m0_icb_cmd_addr),
    .m0_icb_cmd_read  (m0_icb_cmd_read),
    .m0_icb_cmd_wdata (m0_icb_cmd_wdata),
    .m0_icb_cmd_wmask (m0_icb_cmd_wmask),
    .m0_icb_rsp_valid (m0_icb_rsp_valid),
    .m0_icb_rsp_ready (m0_icb_rsp_ready),
    .m0_icb_rsp_err   (m0_icb_rsp_err),
    .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
    .m1_icb_cmd_valid (m1_icb_cmd_valid),
    .m1_icb_cmd_ready (m1_icb_cmd_ready),
    .m1_icb_cmd_addr  (m1_icb_cmd_addr),
    .m1_icb_cmd_read  (m1_icb_cmd_read),
    .m1_icb_cmd_wdata (m1_icb_cmd_wdata),
    .m1_icb_cmd_wmask (m1_icb_cmd_wmask),
    .m1_icb_rsp_valid (m1_icb_rsp_valid),
    .m1_icb_rsp_ready (m1_icb_rsp_ready),
    .m1_icb_rsp_err   (m1_icb_rsp_err),
    .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
    .s_icb_cmd_valid  (s_icb_cmd_valid),
    .s_icb_cmd_ready  (s_icb_cmd_ready),
    .s_icb_cmd_addr   (s_icb_cmd_addr),
    .s_icb_cmd_read   (s_icb_cmd_read),
    .s_icb_cmd_wdata  (s_icb_cmd_wdata),
    .s_icb_cmd_wmask  (s_icb_cmd_wmask),
    .s_icb_rsp_valid  (s_icb_rsp_valid),
    .s_icb_rsp_ready  (s_icb_rsp_ready),
    .s_icb_rsp_err    (s_icb_rsp_err),
    .s_icb_rsp_rdata  (s_icb_rsp_rdata),
    .arb_busy         (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_icb_cmd_valid = 1'b0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 1'b1;
    m0_icb_cmd_wdata = '0;   m0_icb_cmd_wmask = '0; m0_icb_rsp_ready = 1'b1;
    m1_icb_cmd_valid = 1'b0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 1'b1;
    m1_icb_cmd_wdata = '0;   m1_icb_cmd_wmask = '0; m1_icb_rsp_ready = 1'b1;
    s_icb_cmd_ready  = 1'b1; s_icb_rsp_valid = 1'b0; s_icb_rsp_err = 1'b0;
    s_icb_rsp_rdata  = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Reset held with both masters requesting and a stray response present.
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h100;
    m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h200;
    s_icb_rsp_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_icb_cmd_valid !== 1'b0) begin errors++;
      $display("FAIL reset_s_cmd_valid got=%b exp=0", s_icb_cmd_valid); end
    checks++; if (m0_icb_cmd_ready !== 1'b0) begin errors++;
      $display("FAIL reset_m0_cmd_ready got=%b exp=0", m0_icb_cmd_ready); end
    checks++; if (m1_icb_cmd_ready !== 1'b0) begin errors++;
      $display("FAIL reset_m1_cmd_ready got=%b exp=0", m1_icb_cmd_ready); end
    checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== 2'b00) begin errors++;
      $display("FAIL reset_rsp_valid got=%b%b exp=00", m0_icb_rsp_valid, m1_icb_rsp_valid); end
    checks++; if (s_icb_rsp_ready !== 1'b0) begin errors++;
      $display("FAIL reset_s_rsp_ready got=%b exp=0", s_icb_rsp_ready); end
    checks++; if (arb_busy !== 1'b0) begin errors++;
      $display("FAIL reset_arb_busy got=%b exp=0", arb_busy); end
    step();
    rst_n = 1'b1;
    s_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (s_icb_cmd_valid !== 1'b1 || s_icb_cmd_addr !== 32'h100) begin errors++;
      $display("FAIL release_first_grant got valid=%b addr=%h exp valid=1 addr=100",
               s_icb_cmd_valid, s_icb_cmd_addr); end
    checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b10) begin errors++;
      $display("FAIL release_ready got=%b%b exp=10", m0_icb_cmd_ready, m1_icb_cmd_ready); end
    m0_icb_cmd_valid = 1'b0;
    m1_icb_cmd_valid = 1'b0;
  endtask

  // Both masters always valid: grants alternate, FIFO fills, responses return in order.
  task automatic test_round_robin();
    logic [3:0] exp_ext;
    logic       e;
`ifdef ICB_ARB_FIXED_PRIO_EN
    exp_ext = 4'b0000;
`else
    exp_ext = 4'b1010;  // bit i = command i goes to m1
`endif
    apply_reset();
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h100;
    m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      e = exp_ext[i];
      #1;
      checks++; if (s_icb_cmd_addr !== (e ? 32'h200 : 32'h100)) begin errors++;
        $display("FAIL rr_addr[%0d] got=%h exp=%h", i, s_icb_cmd_addr,
                 e ? 32'h200 : 32'h100); end
      checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== {~e, e}) begin errors++;
        $display("FAIL rr_ready[%0d] got=%b%b exp=%b%b", i, m0_icb_cmd_ready,
                 m1_icb_cmd_ready, ~e, e); end
      step();
    end
    #1;
    checks++; if (s_icb_cmd_valid !== 1'b0 || arb_busy !== 1'b1) begin errors++;
      $display("FAIL rr_full got valid=%b busy=%b exp valid=0 busy=1",
               s_icb_cmd_valid, arb_busy); end
    m0_icb_cmd_valid = 1'b0;
    m1_icb_cmd_valid = 1'b0;
    s_icb_rsp_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_ext[i];
      s_icb_rsp_rdata = 32'hA0 + 32'(i);
      #1;
      checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== {~e, e}) begin errors++;
        $display("FAIL rr_rsp_route[%0d] got=%b%b exp=%b%b", i, m0_icb_rsp_valid,
                 m1_icb_rsp_valid, ~e, e); end
      checks++; if ((e ? m1_icb_rsp_rdata : m0_icb_rsp_rdata) !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL rr_rsp_rdata[%0d] got=%h exp=%h", i,
                 e ? m1_icb_rsp_rdata : m0_icb_rsp_rdata, 32'hA0 + 32'(i)); end
      step();
    end
    // FIFO now empty: a stray response must be neither forwarded nor accepted.
    #1;
    checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready} !== 3'b000) begin
      errors++;
      $display("FAIL empty_stray_rsp got=%b%b%b exp=000", m0_icb_rsp_valid,
               m1_icb_rsp_valid, s_icb_rsp_ready); end
    checks++; if (arb_busy !== 1'b0) begin errors++;
      $display("FAIL rr_drained_busy got=%b exp=0", arb_busy); end
    s_icb_rsp_valid = 1'b0;
  endtask

  // Slave stalls m1's write for 3 cycles while m0 arrives; m1's command must stay put.
  task automatic test_lock_stall();
    apply_reset();
    m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h200; m1_icb_cmd_read = 1'b0;
    m1_icb_cmd_wdata = 32'h1122_3344; m1_icb_cmd_wmask = 4'h5;
    m0_icb_cmd_addr  = 32'h100;
    s_icb_cmd_ready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) m0_icb_cmd_valid = 1'b1;
      #1;
      checks++; if (s_icb_cmd_valid !== 1'b1 || s_icb_cmd_addr !== 32'h200) begin errors++;
        $display("FAIL lock_hold[%0d] got valid=%b addr=%h exp valid=1 addr=200", c,
                 s_icb_cmd_valid, s_icb_cmd_addr); end
      checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b00) begin errors++;
        $display("FAIL lock_ready[%0d] got=%b%b exp=00", c, m0_icb_cmd_ready,
                 m1_icb_cmd_ready); end
      step();
    end
    s_icb_cmd_ready = 1'b1;
    #1;
    checks++; if ({s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask}
                  !== {32'h200, 1'b0, 32'h1122_3344, 4'h5}) begin errors++;
      $display("FAIL lock_fields got addr=%h read=%b wdata=%h wmask=%h exp 200/0/11223344/5",
               s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask); end
    checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b01) begin errors++;
      $display("FAIL lock_release_ready got=%b%b exp=01", m0_icb_cmd_ready,
               m1_icb_cmd_ready); end
    step();
    #1;
    checks++; if (s_icb_cmd_addr !== 32'h100 || {m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b10)
    begin errors++;
      $display("FAIL lock_next_grant got addr=%h ready=%b%b exp addr=100 ready=10",
               s_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready); end
    m0_icb_cmd_valid = 1'b0;
    m1_icb_cmd_valid = 1'b0;
  endtask

  // Four outstanding commands fill the FIFO; a pop frees a slot only the following cycle.
  task automatic test_full();
    apply_reset();
    m0_icb_cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_icb_cmd_addr = 32'h1000 + 32'(4 * i);
      #1;
      checks++; if (m0_icb_cmd_ready !== 1'b1) begin errors++;
        $display("FAIL full_fill_ready[%0d] got=%b exp=1", i, m0_icb_cmd_ready); end
      step();
    end
    m0_icb_cmd_addr = 32'h1010;
    #1;
    checks++; if ({m0_icb_cmd_ready, s_icb_cmd_valid, arb_busy} !== 3'b001) begin errors++;
      $display("FAIL full_block got ready=%b valid=%b busy=%b exp 0/0/1", m0_icb_cmd_ready,
               s_icb_cmd_valid, arb_busy); end
    s_icb_rsp_valid = 1'b1;
    #1;
    checks++; if ({m0_icb_rsp_valid, s_icb_rsp_ready, m0_icb_cmd_ready} !== 3'b110) begin
      errors++;
      $display("FAIL full_pop_cycle got rspv=%b rspr=%b cmdr=%b exp 1/1/0",
               m0_icb_rsp_valid, s_icb_rsp_ready, m0_icb_cmd_ready); end
    step();
    s_icb_rsp_valid = 1'b0;
    #1;
    checks++; if ({m0_icb_cmd_ready, s_icb_cmd_valid} !== 2'b11 ||
                  s_icb_cmd_addr !== 32'h1010) begin errors++;
      $display("FAIL full_fifth_issue got ready=%b valid=%b addr=%h exp 1/1/1010",
               m0_icb_cmd_ready, s_icb_cmd_valid, s_icb_cmd_addr); end
    step();
    #1;
    checks++; if (m0_icb_cmd_ready !== 1'b0) begin errors++;
      $display("FAIL full_again got=%b exp=0", m0_icb_cmd_ready); end
    m0_icb_cmd_valid = 1'b0;
  endtask

  // Error response routing and head-of-line back-pressure from the head master.
  task automatic test_rsp_routing();
    apply_reset();
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h300;
    #1;
    checks++; if (m0_icb_cmd_ready !== 1'b1) begin errors++;
      $display("FAIL err_cmd_ready got=%b exp=1", m0_icb_cmd_ready); end
    step();
    m0_icb_cmd_valid = 1'b0;
    s_icb_rsp_valid  = 1'b1; s_icb_rsp_rdata = 32'hDEAD_BEEF; s_icb_rsp_err = 1'b1;
    m1_icb_rsp_ready = 1'b0;
    #1;
    checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== 2'b10) begin errors++;
      $display("FAIL err_route got=%b%b exp=10", m0_icb_rsp_valid, m1_icb_rsp_valid); end
    checks++; if (m0_icb_rsp_err !== 1'b1 || m0_icb_rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL err_payload got err=%b rdata=%h exp err=1 rdata=deadbeef",
               m0_icb_rsp_err, m0_icb_rsp_rdata); end
    checks++; if (s_icb_rsp_ready !== 1'b1) begin errors++;
      $display("FAIL err_s_rsp_ready got=%b exp=1", s_icb_rsp_ready); end
    step();
    s_icb_rsp_valid = 1'b0; s_icb_rsp_err = 1'b0;
    m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h400;
    #1;
    checks++; if (arb_busy !== 1'b0 || m1_icb_cmd_ready !== 1'b1) begin errors++;
      $display("FAIL m1_issue got busy=%b ready=%b exp busy=0 ready=1", arb_busy,
               m1_icb_cmd_ready); end
    step();
    m1_icb_cmd_valid = 1'b0;
    s_icb_rsp_valid  = 1'b1; s_icb_rsp_rdata = 32'h55;
    #1;
    checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready} !== 3'b010) begin
      errors++;
      $display("FAIL hol_block got=%b%b%b exp=010", m0_icb_rsp_valid, m1_icb_rsp_valid,
               s_icb_rsp_ready); end
    step();
    m1_icb_rsp_ready = 1'b1;
    #1;
    checks++; if (arb_busy !== 1'b1 || s_icb_rsp_ready !== 1'b1) begin errors++;
      $display("FAIL hol_release got busy=%b ready=%b exp 1/1", arb_busy, s_icb_rsp_ready); end
    step();
    s_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (arb_busy !== 1'b0) begin errors++;
      $display("FAIL hol_drained got=%b exp=0", arb_busy); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_stall();
    test_full();
    test_rsp_routing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
